// File: rtl/dm.sv
// Shared DMI types and encodings for the JTAG DTM and the Debug Module side.
package dm;

   localparam int DMI_ABITS = 7;

   typedef enum logic [1:0] {
      NOP   = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } dtm_op_e;

   localparam logic [1:0] DTM_SUCCESS = 2'd0;
   localparam logic [1:0] DTM_ERR     = 2'd2;
   localparam logic [1:0] DTM_BUSY    = 2'd3;

   typedef struct packed {
      logic [DMI_ABITS-1:0] addr;
      dtm_op_e              op;
      logic [31:0]          data;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;

   // IEEE 1149.1 TAP controller states
   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_e;

   typedef enum logic [1:0] {
      DMI_IDLE,
      DMI_REQ,
      DMI_WAIT
   } dmi_state_e;

   localparam logic [4:0] IR_IDCODE    = 5'h01;
   localparam logic [4:0] IR_DTMCS     = 5'h10;
   localparam logic [4:0] IR_DMIACCESS = 5'h11;

endpackage

// File: rtl/dmi_jtag_tap.sv
// TAP controller: state machine, IR, IDCODE/BYPASS/DTMCS data registers and
// the scan strobes that let the parent own the 41-bit DMIACCESS register.
module dmi_jtag_tap
   import dm::*;
#(
   parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
   input  logic       tck_i,
   input  logic       trst_ni,
   input  logic       tms_i,
   input  logic       td_i,
   output logic       td_o,
   output logic       tdo_oe_o,
   output logic       dmi_capture,
   output logic       dmi_shift,
   output logic       dmi_update,
   input  logic       dmi_tdo,
   input  logic [1:0] dmistat,
   output logic       dtmcs_dmireset,
   output logic       dtmcs_hardreset,
   output logic       tlr_entry
);

   tap_state_e  state, state_next;
   logic [4:0]  ir, ir_sr;
   logic [31:0] dr_sr;
   logic [31:0] dtmcs_value;
   logic        sel_idcode, sel_dtmcs, sel_dmi, sel_bypass;

   assign sel_idcode = (ir == IR_IDCODE);
   assign sel_dtmcs  = (ir == IR_DTMCS);
   assign sel_dmi    = (ir == IR_DMIACCESS);
   assign sel_bypass = !(sel_idcode || sel_dtmcs || sel_dmi);

   // version=1, abits=7, idle=1; dmistat reflects the sticky DMI error
   assign dtmcs_value = {17'b0, 3'd1, dmistat, 6'd7, 4'd1};

   assign dmi_capture     = sel_dmi && (state == CAP_DR);
   assign dmi_shift       = sel_dmi && (state == SH_DR);
   assign dmi_update      = sel_dmi && (state == UPD_DR);
   assign dtmcs_dmireset  = sel_dtmcs && (state == UPD_DR) && dr_sr[16];
   assign dtmcs_hardreset = sel_dtmcs && (state == UPD_DR) && dr_sr[17];
   assign tlr_entry       = (state != TLR) && (state_next == TLR);
   assign tdo_oe_o        = (state == SH_IR) || (state == SH_DR);

   // TAP next-state decode from tms_i
   always_comb begin
      state_next = state;
      case (state)
         TLR:    state_next = tms_i ? TLR    : RTI;
         RTI:    state_next = tms_i ? SEL_DR : RTI;
         SEL_DR: state_next = tms_i ? SEL_IR : CAP_DR;
         CAP_DR: state_next = tms_i ? EX1_DR : SH_DR;
         SH_DR:  state_next = tms_i ? EX1_DR : SH_DR;
         EX1_DR: state_next = tms_i ? UPD_DR : PAU_DR;
         PAU_DR: state_next = tms_i ? EX2_DR : PAU_DR;
         EX2_DR: state_next = tms_i ? UPD_DR : SH_DR;
         UPD_DR: state_next = tms_i ? SEL_DR : RTI;
         SEL_IR: state_next = tms_i ? TLR    : CAP_IR;
         CAP_IR: state_next = tms_i ? EX1_IR : SH_IR;
         SH_IR:  state_next = tms_i ? EX1_IR : SH_IR;
         EX1_IR: state_next = tms_i ? UPD_IR : PAU_IR;
         PAU_IR: state_next = tms_i ? EX2_IR : PAU_IR;
         EX2_IR: state_next = tms_i ? UPD_IR : SH_IR;
         UPD_IR: state_next = tms_i ? SEL_DR : RTI;
         default: state_next = TLR;
      endcase
   end

   // TAP state register
   always_ff @(posedge tck_i) begin
      if (!trst_ni) state <= TLR;
      else          state <= state_next;
   end

   // Instruction register: capture, LSB-first shift, commit; TLR selects IDCODE
   always_ff @(posedge tck_i) begin
      if (!trst_ni) begin
         ir    <= IR_IDCODE;
         ir_sr <= '0;
      end else begin
         case (state)
            CAP_IR:  ir_sr <= 5'b00001;
            SH_IR:   ir_sr <= {td_i, ir_sr[4:1]};
            UPD_IR:  ir    <= ir_sr;
            TLR:     ir    <= IR_IDCODE;
            default: ;
         endcase
      end
   end

   // Shared IDCODE/DTMCS/BYPASS shift register; BYPASS uses only bit 0
   always_ff @(posedge tck_i) begin
      if (!trst_ni) begin
         dr_sr <= '0;
      end else if (state == CAP_DR) begin
         if (sel_idcode)     dr_sr <= IdcodeValue;
         else if (sel_dtmcs) dr_sr <= dtmcs_value;
         else                dr_sr <= '0;
      end else if (state == SH_DR) begin
         if (sel_bypass) dr_sr <= {31'b0, td_i};
         else            dr_sr <= {td_i, dr_sr[31:1]};
      end
   end

   // Present the selected register LSB on the falling edge
   always_ff @(negedge tck_i) begin
      if (state == SH_IR)      td_o <= ir_sr[0];
      else if (state == SH_DR) td_o <= sel_dmi ? dmi_tdo : dr_sr[0];
      else                     td_o <= 1'b0;
   end

endmodule

// File: rtl/dmi_jtag.sv
// JTAG DTM: TAP plus the DMIACCESS register and the DMI request/response FSM.
module dmi_jtag
   import dm::*;
#(
   parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
   input  logic          tck_i,
   input  logic          trst_ni,
   input  logic          tms_i,
   input  logic          td_i,
   output logic          td_o,
   output logic          tdo_oe_o,
   output logic          dmi_clear_o,
   output dm::dmi_req_t  dmi_req_o,
   output logic          dmi_req_valid_o,
   input  logic          dmi_req_ready_i,
   input  dm::dmi_resp_t dmi_resp_i,
   output logic          dmi_resp_ready_o,
   input  logic          dmi_resp_valid_i
);

   dmi_state_e  state, state_next;
   logic [1:0]  error;
   logic [6:0]  addr;
   logic [31:0] data;
   dtm_op_e     op;
   dtm_op_e     scan_op;
   logic [40:0] dr;
   logic        dmi_capture, dmi_shift, dmi_update;
   logic        dmireset, hardreset, tlr_entry;
   logic        abort, start;

   dmi_jtag_tap #(.IdcodeValue(IdcodeValue)) u_tap (
      .tck_i           (tck_i),
      .trst_ni         (trst_ni),
      .tms_i           (tms_i),
      .td_i            (td_i),
      .td_o            (td_o),
      .tdo_oe_o        (tdo_oe_o),
      .dmi_capture     (dmi_capture),
      .dmi_shift       (dmi_shift),
      .dmi_update      (dmi_update),
      .dmi_tdo         (dr[0]),
      .dmistat         (error),
      .dtmcs_dmireset  (dmireset),
      .dtmcs_hardreset (hardreset),
      .tlr_entry       (tlr_entry)
   );

   assign scan_op = dtm_op_e'(dr[1:0]);
   assign abort   = hardreset || tlr_entry;
   // A new access only starts from Idle with no sticky error pending
   assign start   = dmi_update && (state == DMI_IDLE) && (error == DTM_SUCCESS) &&
                    ((scan_op == READ) || (scan_op == WRITE));

   assign dmi_req_o        = {addr, op, data};
   assign dmi_req_valid_o  = (state == DMI_REQ);
   assign dmi_resp_ready_o = (state == DMI_WAIT);

   // DMI handshake sequencing; hard reset or TLR entry aborts to Idle
   always_comb begin
      state_next = state;
      case (state)
         DMI_IDLE: if (start)            state_next = DMI_REQ;
         DMI_REQ:  if (dmi_req_ready_i)  state_next = DMI_WAIT;
         DMI_WAIT: if (dmi_resp_valid_i) state_next = DMI_IDLE;
         default:                        state_next = DMI_IDLE;
      endcase
      if (abort) state_next = DMI_IDLE;
   end

   // DMI FSM state register
   always_ff @(posedge tck_i) begin
      if (!trst_ni) state <= DMI_IDLE;
      else          state <= state_next;
   end

   // DMIACCESS scan register, latched request/response and sticky error
   always_ff @(posedge tck_i) begin
      if (!trst_ni) begin
         error       <= DTM_SUCCESS;
         addr        <= '0;
         data        <= '0;
         op          <= NOP;
         dr          <= '0;
         dmi_clear_o <= 1'b0;
      end else begin
         dmi_clear_o <= abort;
         if (dmi_capture)
            dr <= {addr, data, (state != DMI_IDLE) ? DTM_BUSY : error};
         else if (dmi_shift)
            dr <= {td_i, dr[40:1]};
         if (start) begin
            addr <= dr[40:34];
            data <= dr[33:2];
            op   <= scan_op;
         end
         if ((state == DMI_WAIT) && dmi_resp_valid_i) begin
            // writes keep the written data so a later capture echoes it
            if (op == READ) data <= dmi_resp_i.data;
            if (dmi_resp_i.resp != DTM_SUCCESS) error <= DTM_ERR;
         end
         // an access attempted while one is in flight is lost; flag it
         if (dmi_update && (state != DMI_IDLE)) error <= DTM_BUSY;
         if (dmireset || abort) error <= DTM_SUCCESS;
      end
   end

endmodule

// File: tb/tb_dmi_jtag.sv
// Scoreboard bench for dmi_jtag: expected DMI requests and expected scan-out
// values are queued by the stimulus and popped by independent monitors.
module tb_dmi_jtag;
   import dm::*;

   localparam logic [31:0] IDC = 32'h2495_11C3;

   logic      tck_i = 1'b0;
   logic      trst_ni = 1'b0;
   logic      tms_i = 1'b1;
   logic      td_i = 1'b0;
   logic      td_o, tdo_oe_o, dmi_clear_o;
   dmi_req_t  dmi_req_o;
   logic      dmi_req_valid_o;
   logic      dmi_req_ready_i = 1'b0;
   dmi_resp_t dmi_resp_i = '0;
   logic      dmi_resp_ready_o;
   logic      dmi_resp_valid_i = 1'b0;

   typedef struct {
      int          len;
      logic [63:0] val;
      string       name;
   } cap_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_clear = 0;
   dmi_req_t    req_q[$];
   cap_t        cap_q[$];
   logic [63:0] sh_bits = '0;
   int          sh_cnt = 0;
   cap_t        cap_cur;

   dmi_jtag #(.IdcodeValue(IDC)) dut (
      .tck_i            (tck_i),
      .trst_ni          (trst_ni),
      .tms_i            (tms_i),
      .td_i             (td_i),
      .td_o             (td_o),
      .tdo_oe_o         (tdo_oe_o),
      .dmi_clear_o      (dmi_clear_o),
      .dmi_req_o        (dmi_req_o),
      .dmi_req_valid_o  (dmi_req_valid_o),
      .dmi_req_ready_i  (dmi_req_ready_i),
      .dmi_resp_i       (dmi_resp_i),
      .dmi_resp_ready_o (dmi_resp_ready_o),
      .dmi_resp_valid_i (dmi_resp_valid_i)
   );

   always #5 tck_i = ~tck_i;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got nothing expected an event", name);
   endfunction

   function automatic dmi_req_t mkreq(logic [6:0] a, dtm_op_e o, logic [31:0] d);
      dmi_req_t r;
      r.addr = a;
      r.op   = o;
      r.data = d;
      return r;
   endfunction

   // Scan-out monitor: gathers td_o while shifting, compares when shifting ends
   always @(negedge tck_i) begin
      #2;
      if (tdo_oe_o) begin
         if (sh_cnt < 64) sh_bits[sh_cnt] = td_o;
         sh_cnt++;
      end else if (sh_cnt > 0) begin
         if (cap_q.size() == 0) begin
            fail_now("scan_unexpected");
         end else begin
            cap_cur = cap_q.pop_front();
            check({cap_cur.name, "_len"}, 64'(sh_cnt), 64'(cap_cur.len));
            check(cap_cur.name, sh_bits, cap_cur.val);
         end
         sh_cnt  = 0;
         sh_bits = '0;
      end
   end

   // Request monitor: every accepted handshake must match the next expected request
   always @(negedge tck_i) begin
      #2;
      if (trst_ni && dmi_clear_o) n_clear++;
      if (dmi_req_valid_o && dmi_req_ready_i) begin
         if (req_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: got %h expected no request", dmi_req_o);
         end else begin
            check("dmi_req", {23'b0, dmi_req_o}, {23'b0, req_q.pop_front()});
         end
      end
   end

   task automatic tick(input logic tms, input logic tdi);
      @(negedge tck_i);
      tms_i = tms;
      td_i  = tdi;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
   endtask

   task automatic scan_ir(input logic [4:0] v);
      cap_t c;
      c.len = 5; c.val = 64'd1; c.name = "ir_capture";
      cap_q.push_back(c);
      tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < 5; i++) tick(i == 4, v[i]);
      tick(1, 0); tick(0, 0);
   endtask

   task automatic scan_dr(input int len, input logic [63:0] v, input logic [63:0] exp,
                          input string name);
      cap_t c;
      c.len = len; c.val = exp; c.name = name;
      cap_q.push_back(c);
      tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < len; i++) tick(i == len - 1, v[i]);
      tick(1, 0); tick(0, 0);
   endtask

   task automatic wait_req(input string name, output int cyc);
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge tck_i); #1;
         if (dmi_req_valid_o) begin
            cyc = i;
            return;
         end
      end
      fail_now(name);
   endtask

   task automatic respond(input logic [31:0] d, input logic [1:0] r);
      for (int i = 0; i < 20; i++) begin
         @(negedge tck_i); #1;
         if (dmi_resp_ready_o) begin
            dmi_resp_i.data  = d;
            dmi_resp_i.resp  = r;
            dmi_resp_valid_i = 1'b1;
            @(negedge tck_i);
            dmi_resp_valid_i = 1'b0;
            dmi_resp_i       = '0;
            return;
         end
      end
      fail_now("resp_ready_timeout");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int clr0;

      // reset
      repeat (3) @(negedge tck_i);
      #2;
      check("rst_req_valid", dmi_req_valid_o, 0);
      check("rst_resp_ready", dmi_resp_ready_o, 0);
      check("rst_clear", dmi_clear_o, 0);
      check("rst_tdo_oe", tdo_oe_o, 0);
      check("rst_td_o", td_o, 0);
      @(negedge tck_i);
      trst_ni = 1'b1;
      tick(0, 0);

      // IDCODE is the default instruction
      scan_dr(32, 64'd0, {32'b0, IDC}, "idcode");

      // unknown IR selects the 1-bit bypass register
      scan_ir(5'h1F);
      scan_dr(4, 64'b1010, 64'b0100, "bypass");

      // DTMCS at rest
      scan_ir(5'h10);
      scan_dr(32, 64'd0, 64'h1071, "dtmcs_idle");

      // DMI write
      scan_ir(5'h11);
      dmi_req_ready_i = 1'b1;
      req_q.push_back(mkreq(7'h10, WRITE, 32'h07FF_FFC1));
      scan_dr(41, {7'h10, 32'h07FF_FFC1, 2'b10}, 64'd0, "dmi_cap_reset");
      #1;
      check("req_valid_before_update", dmi_req_valid_o, 0);
      wait_req("write_req_timeout", cyc);
      check("write_req_latency", 64'(cyc), 64'd1);
      @(negedge tck_i); #1;
      check("write_valid_drop", dmi_req_valid_o, 0);
      check("write_resp_ready", dmi_resp_ready_o, 1);
      respond(32'h0, DTM_SUCCESS);
      #1;
      check("resp_ready_idle", dmi_resp_ready_o, 0);

      // DMI read of 0x10
      req_q.push_back(mkreq(7'h10, READ, 32'h0));
      scan_dr(41, 64'h040_0000_0001, {7'h10, 32'h07FF_FFC1, 2'b00}, "dmi_cap_write");
      respond(32'h4, DTM_SUCCESS);
      scan_dr(41, 64'd0, {7'h10, 32'h4, 2'b00}, "dmi_cap_read");

      // second access while one is in flight
      dmi_req_ready_i = 1'b0;
      req_q.push_back(mkreq(7'h05, READ, 32'h0));
      scan_dr(41, {7'h05, 32'h0, 2'b01}, {7'h10, 32'h4, 2'b00}, "dmi_cap_read2");
      wait_req("busy_req_timeout", cyc);
      idle(3);
      #1;
      check("req_hold_valid", dmi_req_valid_o, 1);
      check("req_hold_payload", {23'b0, dmi_req_o}, {23'b0, mkreq(7'h05, READ, 32'h0)});
      scan_dr(41, {7'h06, 32'h0000_AAAA, 2'b10}, {7'h05, 32'h0, 2'd3}, "dmi_cap_busy");
      @(negedge tck_i);
      dmi_req_ready_i = 1'b1;
      respond(32'h1234_5678, DTM_SUCCESS);
      scan_dr(41, {7'h07, 32'h55, 2'b10}, {7'h05, 32'h1234_5678, 2'd3}, "dmi_cap_sticky_busy");
      idle(5);
      #1;
      check("no_req_while_busy_sticky", dmi_req_valid_o, 0);
      scan_ir(5'h10);
      scan_dr(32, 64'h0001_0000, 64'h1C71, "dtmcs_busy");
      scan_dr(32, 64'd0, 64'h1071, "dtmcs_busy_cleared");

      // error response
      scan_ir(5'h11);
      req_q.push_back(mkreq(7'h11, READ, 32'h0));
      scan_dr(41, {7'h11, 32'h0, 2'b01}, {7'h05, 32'h1234_5678, 2'd0}, "dmi_cap_cleared");
      respond(32'hDEAD_BEEF, DTM_ERR);
      scan_dr(41, {7'h12, 32'h0, 2'b10}, {7'h11, 32'hDEAD_BEEF, 2'd2}, "dmi_cap_err");
      idle(5);
      #1;
      check("no_req_while_err_sticky", dmi_req_valid_o, 0);
      scan_ir(5'h10);
      scan_dr(32, 64'h0001_0000, 64'h1871, "dtmcs_err");
      scan_dr(32, 64'd0, 64'h1071, "dtmcs_err_cleared");

      // dmihardreset aborts an in-flight request
      scan_ir(5'h11);
      dmi_req_ready_i = 1'b0;
      scan_dr(41, {7'h20, 32'h0, 2'b01}, {7'h11, 32'hDEAD_BEEF, 2'd0}, "dmi_cap_pre_hard");
      wait_req("hard_req_timeout", cyc);
      clr0 = n_clear;
      scan_ir(5'h10);
      scan_dr(32, 64'h0002_0000, 64'h1071, "dtmcs_pre_hard");
      idle(3);
      #3;
      check("hard_clear_pulses", 64'(n_clear - clr0), 64'd1);
      check("hard_abort_valid", dmi_req_valid_o, 0);
      check("hard_abort_resp_ready", dmi_resp_ready_o, 0);

      // TMS-driven reset aborts an in-flight request
      scan_ir(5'h11);
      scan_dr(41, {7'h21, 32'h0, 2'b01}, {7'h20, 32'h0, 2'd0}, "dmi_cap_post_hard");
      wait_req("tlr_req_timeout", cyc);
      clr0 = n_clear;
      repeat (5) tick(1, 0);
      tick(0, 0);
      idle(2);
      #3;
      check("tlr_clear_pulses", 64'(n_clear - clr0), 64'd1);
      check("tlr_abort_valid", dmi_req_valid_o, 0);
      scan_dr(32, 64'd0, {32'b0, IDC}, "idcode_after_tlr");

      idle(3);
      #3;
      check("req_q_empty", 64'(req_q.size()), 64'd0);
      check("cap_q_empty", 64'(cap_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
